// File: rtl/mealy_pkg.sv
// Shared definitions for the Mealy event counter: FSM state encoding and
// default sizing constants.
package mealy_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_THRESH = 10;

  // 2'b11 is deliberately left unused; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    SAT   = 2'b10
  } state_t;

endpackage

// File: rtl/mealy_event_counter_if.sv
// Control and status bundle between the event-counter host and the counter.
// The master drives the event input and controls; the slave returns count,
// flags and the debug state.
interface mealy_event_counter_if
  import mealy_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             y_in;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             thresh_hit;
  logic             sat;
  logic [1:0]       state_o;

  modport master (
    output y_in, en, clr,
    input  count, thresh_hit, sat, state_o
  );

  modport slave (
    input  y_in, en, clr,
    output count, thresh_hit, sat, state_o
  );

endinterface

// File: rtl/mealy_evt_qual.sv
// Event qualifier for the upstream detector output.
// Build option MEALY_EVT_EDGE_EN: when defined, only a rising edge of y_in
// is an event (a held-high input counts once); otherwise every high cycle
// is an event.
module mealy_evt_qual (
  input  logic clk,
  input  logic rst,
  input  logic y_in,
  output logic evt
);

`ifdef MEALY_EVT_EDGE_EN
  logic y_prev_q;

  // Previous-sample history; reset clears it so a pre-reset high is not
  // mistaken for an already-seen level.
  always_ff @(posedge clk) begin
    if (rst) y_prev_q <= 1'b0;
    else     y_prev_q <= y_in;
  end

  assign evt = y_in & ~y_prev_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign evt            = y_in;
`endif

endmodule

// File: rtl/mealy_event_counter.sv
// Event counter behind a Mealy sequence detector.
// Counts qualified events while enabled, pulses thresh_hit when the count
// first reaches THRESH, and saturates at all-ones until clr or rst.
// Event qualification (edge vs level) is selected by MEALY_EVT_EDGE_EN,
// see mealy_evt_qual.
//
//   state | meaning
//   IDLE  | count held, y_in ignored; en=1 moves to COUNT
//   COUNT | qualified events increment count; en=0 returns to IDLE
//   SAT   | count pinned at all-ones, sat=1; left only via clr/rst
module mealy_event_counter
  import mealy_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH
) (
  input logic                  clk,
  input logic                  rst,
  mealy_event_counter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] count_inc;
  logic             evt;

  mealy_evt_qual u_qual (
    .clk  (clk),
    .rst  (rst),
    .y_in (bus.y_in),
    .evt  (evt)
  );

  assign count_inc = count_q + CNT_W'(1);

  // State, count and threshold-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state and count update; clr wins over any event in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hit_d   = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) state_d = COUNT;
        end
        COUNT: begin
          if (!bus.en) begin
            state_d = IDLE;
          end else if (evt) begin
            count_d = count_inc;
            hit_d   = (count_inc == THRESH_V);
            if (count_inc == CNT_MAX) state_d = SAT;
          end
        end
        SAT: begin
          state_d = SAT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.count      = count_q;
  assign bus.thresh_hit = hit_q;
  assign bus.sat        = (state_q == SAT);
  assign bus.state_o    = state_q;

endmodule
